// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the BaseRAM arbiter: FSM states, grant encoding,
// SRAM bus widths and the wait-state counter width.
package sram_arb_pkg;

   localparam int SRAM_AW = 20;
   localparam int DW      = 32;
   localparam int WAIT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_DONE
   } state_t;

   typedef enum logic {
      GRANT_IF  = 1'b0,
      GRANT_MEM = 1'b1
   } grant_t;

   // Clamp a wait-state count into the counter's range.
   function automatic logic [WAIT_W-1:0] wait_load(input int unsigned cycles);
      return (cycles > 7) ? 3'd7 : WAIT_W'(cycles);
   endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational winner selection between fetch and data requests.
// With SRAM_ARB_FAIR_EN defined, contention alternates against the last grant.
module sram_arb_grant
   import sram_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   mem_req,
`ifdef SRAM_ARB_FAIR_EN
   input  grant_t last_grant,
`endif
   output logic   grant_valid,
   output grant_t grant
);

   always_comb begin
      grant_valid = if_req | mem_req;
      grant       = GRANT_MEM;
`ifdef SRAM_ARB_FAIR_EN
      if (if_req && mem_req) begin
         grant = (last_grant == GRANT_MEM) ? GRANT_IF : GRANT_MEM;
      end else if (if_req) begin
         grant = GRANT_IF;
      end
`else
      if (if_req && !mem_req) begin
         grant = GRANT_IF;
      end
`endif
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares the BaseRAM port between instruction fetch and data access, sequencing
// multi-cycle reads/writes with WAIT_CYCLES wait states. Fair grant: SRAM_ARB_FAIR_EN.
module sram_bus_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   output logic [DW-1:0]      if_rdata,
   output logic               if_ack,
   output logic               if_stall,
   input  logic               mem_req,
   input  logic               mem_we,
   input  logic [3:0]         mem_be,
   input  logic [31:0]        mem_addr,
   input  logic [DW-1:0]      mem_wdata,
   output logic [DW-1:0]      mem_rdata,
   output logic               mem_ack,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [DW-1:0]      sram_wdata,
   output logic               sram_data_oe,
   input  logic [DW-1:0]      sram_rdata,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [3:0]         sram_be_n
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   state_t              state;
   grant_t              owner;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                grant_valid;
   grant_t              grant;
   logic                win_we;
   logic [3:0]          win_be;
   logic [SRAM_AW-1:0]  win_word;
   logic [DW-1:0]       win_wdata;

   // Byte-lane and high address bits never reach the 1M-word SRAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

   assign if_stall = if_req & ~if_ack;

   sram_arb_grant u_grant (
      .if_req      (if_req),
      .mem_req     (mem_req),
`ifdef SRAM_ARB_FAIR_EN
      .last_grant  (owner),
`endif
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Fetch is always a full-word read; only the data port can write.
   always_comb begin
      if (grant == GRANT_MEM) begin
         win_we    = mem_we;
         win_be    = mem_be;
         win_word  = mem_addr[21:2];
         win_wdata = mem_wdata;
      end else begin
         win_we    = 1'b0;
         win_be    = 4'h0;
         win_word  = if_addr[21:2];
         win_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         owner        <= GRANT_MEM;
         wait_cnt     <= '0;
         sram_addr    <= '0;
         sram_wdata   <= '0;
         sram_data_oe <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= 4'hF;
         if_ack       <= 1'b0;
         mem_ack      <= 1'b0;
         if_rdata     <= '0;
         mem_rdata    <= '0;
      end else begin
         // Acks are high only for the single DONE cycle.
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner      <= grant;
                  sram_addr  <= win_word;
                  sram_wdata <= win_wdata;
                  wait_cnt   <= WAIT_LOAD;
                  if (!win_we) begin
                     state     <= ST_RD;
                     sram_ce_n <= 1'b0;
                     sram_oe_n <= 1'b0;
                     sram_be_n <= 4'h0;
                  end else if (win_be != 4'h0) begin
                     state        <= ST_WR_SETUP;
                     sram_ce_n    <= 1'b0;
                     sram_data_oe <= 1'b1;
                     sram_be_n    <= ~win_be;
                  end else begin
                     // Empty write: nothing to strobe, complete immediately.
                     state <= ST_DONE;
                     if (grant == GRANT_MEM) mem_ack <= 1'b1;
                     else                    if_ack  <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               if (wait_cnt == '0) begin
                  state     <= ST_DONE;
                  wait_cnt  <= WAIT_LOAD;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_be_n <= 4'hF;
                  if (owner == GRANT_MEM) begin
                     mem_rdata <= sram_rdata;
                     mem_ack   <= 1'b1;
                  end else begin
                     if_rdata  <= sram_rdata;
                     if_ack    <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_WR_SETUP: begin
               state     <= ST_WR_PULSE;
               wait_cnt  <= WAIT_LOAD;
               sram_we_n <= 1'b0;
            end
            ST_WR_PULSE: begin
               if (wait_cnt == '0) begin
                  state     <= ST_WR_HOLD;
                  wait_cnt  <= WAIT_LOAD;
                  sram_we_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               state        <= ST_DONE;
               wait_cnt     <= WAIT_LOAD;
               sram_ce_n    <= 1'b1;
               sram_data_oe <= 1'b0;
               sram_be_n    <= 4'hF;
               if (owner == GRANT_MEM) mem_ack <= 1'b1;
               else                    if_ack  <= 1'b1;
            end
            ST_DONE: begin
               // Requests are still high here; returning to IDLE first avoids re-service.
               state    <= ST_IDLE;
               wait_cnt <= WAIT_LOAD;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
